// File: rtl/four_bit_counter.sv
// Up/down counter with asynchronous active-high reset and modulo wrap-around.
// Define FOUR_BIT_COUNTER_SAT_EN to make the count saturate at both ends instead.
module four_bit_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  input  logic             decrement,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam logic [WIDTH-1:0] MIN_VAL = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;

  // Both commands high is a deliberate hold, same as both low.
  always_comb begin
    count_next = count_reg;
    case ({increment, decrement})
      2'b10: begin
`ifdef FOUR_BIT_COUNTER_SAT_EN
        if (count_reg != MAX_VAL) count_next = count_reg + ONE;
`else
        count_next = count_reg + ONE;
`endif
      end
      2'b01: begin
`ifdef FOUR_BIT_COUNTER_SAT_EN
        if (count_reg != MIN_VAL) count_next = count_reg - ONE;
`else
        count_next = count_reg - ONE;
`endif
      end
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_reg <= RST_VAL;
    else       count_reg <= count_next;
  end

  assign count = count_reg;

endmodule

// File: tb/tb_four_bit_counter.sv
// Self-checking bench for four_bit_counter: vector table plus hand sequences,
// with expected counts queued at drive time and popped after each clock edge.
module tb_four_bit_counter;

  localparam int W = 4;
`ifdef FOUR_BIT_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         increment = 1'b0;
  logic         decrement = 1'b0;
  logic [W-1:0] count;

  always #5 clk = ~clk;

  four_bit_counter #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .clk(clk),
    .reset(reset),
    .increment(increment),
    .decrement(decrement),
    .count(count)
  );

  typedef struct {
    logic         inc;
    logic         dec;
    logic [W-1:0] exp;
    string        name;
  } vec_t;

  vec_t         vecs[12];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: count=%0d expected=%0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: count=%0d at %0t", name, act, $time);
    end
  endtask

  // Drive one command, queue its expected result, compare just after the edge.
  task automatic step(input logic inc, input logic dec, input logic [W-1:0] exp, input string name);
    logic [W-1:0] e;
    increment = inc;
    decrement = dec;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, count=%0d", name, count);
    end else begin
      e = exp_q.pop_front();
      check(name, count, e);
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    increment = 1'b0;
    decrement = 1'b0;
    reset = 1'b1;
    #1;
    check({name, "_assert"}, count, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check({name, "_release"}, count, 4'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 4'd1, "tbl_inc_1"};
    vecs[1]  = '{1'b1, 1'b0, 4'd2, "tbl_inc_2"};
    vecs[2]  = '{1'b0, 1'b1, 4'd1, "tbl_dec_1"};
    vecs[3]  = '{1'b0, 1'b0, 4'd1, "tbl_idle"};
    vecs[4]  = '{1'b1, 1'b1, 4'd1, "tbl_both"};
    vecs[5]  = '{1'b0, 1'b1, 4'd0, "tbl_dec_0"};
    vecs[6]  = '{1'b0, 1'b1, SAT ? 4'd0 : 4'd15, "tbl_dec_under"};
    vecs[7]  = '{1'b1, 1'b0, SAT ? 4'd1 : 4'd0,  "tbl_inc_after_under"};
    vecs[8]  = '{1'b1, 1'b0, SAT ? 4'd2 : 4'd1,  "tbl_inc_again"};
    vecs[9]  = '{1'b1, 1'b1, SAT ? 4'd2 : 4'd1,  "tbl_both_hold"};
    vecs[10] = '{1'b0, 1'b1, SAT ? 4'd1 : 4'd0,  "tbl_dec_again"};
    vecs[11] = '{1'b0, 1'b0, SAT ? 4'd1 : 4'd0,  "tbl_idle_end"};

    // Reset pulse mid-period, then idle edges.
    do_reset("rst_pulse");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, "rst_idle");

    // Vector table from 0.
    for (int i = 0; i < 12; i++) step(vecs[i].inc, vecs[i].dec, vecs[i].exp, vecs[i].name);

    // Up then down, then a long idle stretch.
    do_reset("updown");
    step(1'b1, 1'b0, 4'd1, "updown_inc1");
    step(1'b1, 1'b0, 4'd2, "updown_inc2");
    step(1'b0, 1'b1, 4'd1, "updown_dec");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 4'd1, "updown_idle");

    // Upward wrap (or saturation) after 16 increments.
    do_reset("wrap_up");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 4'(i + 1), "wrap_up_climb");
    step(1'b1, 1'b0, SAT ? 4'd15 : 4'd0, "wrap_up_top");

    // Downward wrap (or saturation) from 0.
    do_reset("wrap_dn");
    step(1'b0, 1'b1, SAT ? 4'd0 : 4'd15, "wrap_dn_bottom");

    // Both commands held at 5.
    do_reset("both");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 1), "both_climb");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'd5, "both_hold");

    // Asynchronous reset mid-count with increment held.
    do_reset("async");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 4'(i + 1), "async_climb");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("async_rst_immediate", count, 4'd0);
    @(posedge clk);
    #1;
    check("async_rst_held", count, 4'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("async_first_edge", count, 4'd1);

    // Latency: increment raised 1 unit after an edge acts only at the next edge.
    increment = 1'b0;
    @(posedge clk);
    #1;
    check("lat_idle", count, 4'd1);
    increment = 1'b1;
    check("lat_no_comb", count, 4'd1);
    @(negedge clk);
    check("lat_midcycle", count, 4'd1);
    @(posedge clk);
    #1;
    check("lat_next_edge", count, 4'd2);
    increment = 1'b0;

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
